// File: rtl/serial_cmp_ctrl.sv
// rtl/serial_cmp_ctrl.sv - bit-serial MSB-first magnitude comparator controller
//
// Purpose:
//    Captures two WIDTH-bit unsigned operands on start and walks them one bit
//    per clock from the MSB down. A single shared xorgate cell computes the
//    per-bit difference. The first differing bit decides gt/lt. If no bit
//    differs, eq is set. Uses a start/busy/done handshake.
//
// Configuration macro:
//    SERCMP_EARLY_EXIT_EN - when defined, SCAN ends on the first differing bit.
//                           When undefined, all WIDTH bits are always scanned.
//
// Ports:
//    clk    in   1      rising-edge clock
//    rst_n  in   1      asynchronous active-low reset
//    start  in   1      comparison request, sampled only in IDLE
//    a      in   WIDTH  operand A, captured when start is accepted
//    b      in   WIDTH  operand B, captured when start is accepted
//    busy   out  1      high in SCAN and DONE
//    done   out  1      one-cycle pulse, results valid
//    eq     out  1      A == B
//    gt     out  1      A > B
//    lt     out  1      A < B

module xorgate (
   input  logic a,
   input  logic b,
   output logic y
);
   assign y = a ^ b;
endmodule

module serial_cmp_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             eq,
   output logic             gt,
   output logic             lt
);

   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [WIDTH-1:0] reg_a_q, reg_a_d;
   logic [WIDTH-1:0] reg_b_q, reg_b_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             eq_q, eq_d;
   logic             gt_q, gt_d;
   logic             lt_q, lt_d;

   logic ba, bb, diff;
   logic decided;
   logic early_exit;

   assign ba = reg_a_q[idx_q];
   assign bb = reg_b_q[idx_q];

   xorgate u_xorgate (
      .a (ba),
      .b (bb),
      .y (diff)
   );

   // gt/lt are cleared on acceptance, so either being set means an earlier
   // bit already decided the result and later bits must not overwrite it.
   assign decided = gt_q | lt_q;

`ifdef SERCMP_EARLY_EXIT_EN
   assign early_exit = diff | decided;
`else
   assign early_exit = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      reg_a_d = reg_a_q;
      reg_b_d = reg_b_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      eq_d    = eq_q;
      gt_d    = gt_q;
      lt_d    = lt_q;

      case (state_q)
         S_IDLE: begin
            busy_d = 1'b0;
            if (start) begin
               reg_a_d = a;
               reg_b_d = b;
               idx_d   = IW'(WIDTH - 1);
               eq_d    = 1'b0;
               gt_d    = 1'b0;
               lt_d    = 1'b0;
               busy_d  = 1'b1;
               state_d = S_SCAN;
            end
         end

         S_SCAN: begin
            if (diff && !decided) begin
               gt_d = ba;
               lt_d = bb;
               eq_d = 1'b0;
            end
            if ((idx_q == '0) || early_exit) begin
               // done/busy are registered, so raise them on the way into
               // DONE so they are visible for exactly that one cycle.
               if (!decided && !diff) begin
                  eq_d = 1'b1;
               end
               done_d  = 1'b1;
               busy_d  = 1'b1;
               state_d = S_DONE;
            end else begin
               idx_d = idx_q - IW'(1);
            end
         end

         S_DONE: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end

         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         reg_a_q <= '0;
         reg_b_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         eq_q    <= 1'b0;
         gt_q    <= 1'b0;
         lt_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         reg_a_q <= reg_a_d;
         reg_b_q <= reg_b_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         eq_q    <= eq_d;
         gt_q    <= gt_d;
         lt_q    <= lt_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign eq   = eq_q;
   assign gt   = gt_q;
   assign lt   = lt_q;

endmodule

// File: tb/tb_serial_cmp_ctrl.sv
// tb/tb_serial_cmp_ctrl.sv - scoreboard testbench for serial_cmp_ctrl
//
// Purpose:
//    Directed vectors with hand-computed results. The expected {eq,gt,lt} and
//    the expected done cycle are queued when each start is issued. A monitor
//    pops and compares them on every done pulse.
//
// Ports:
//    none (top-level bench)

module tb_serial_cmp_ctrl;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a_i;
   logic [W-1:0] b_i;
   logic         busy;
   logic         done;
   logic         eq;
   logic         gt;
   logic         lt;

   typedef struct {
      logic [2:0] res;
      int         cyc;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   pass_cnt = 0;
   int   total_cnt = 0;

   serial_cmp_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a_i),
      .b     (b_i),
      .busy  (busy),
      .done  (done),
      .eq    (eq),
      .gt    (gt),
      .lt    (lt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint exp);
      total_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Done latency for first differing bit j (WIDTH=8).
   function automatic int lat(input int j);
`ifdef SERCMP_EARLY_EXIT_EN
      return W - j + 1;
`else
      return W + 1;
`endif
   endfunction

   // Monitor: each done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (sb.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_done: got done=1 expected no pending request (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("result_eq_gt_lt", {eq, gt, lt}, e.res);
            check("done_cycle", cyc, e.cyc);
         end
      end
   end

   // Called at a negedge; that cycle is cycle 0. Returns at cycle 1.
   task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [2:0] res, input int latency, input bit push);
      exp_t e;
      a_i   = av;
      b_i   = bv;
      start = 1'b1;
      if (push) begin
         e.res = res;
         e.cyc = cyc + latency;
         sb.push_back(e);
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   // Wait (bounded) for all expectations to be consumed, then step past DONE.
   task automatic drain();
      for (int i = 0; i < 40; i++) begin
         if (sb.size() == 0) break;
         @(negedge clk);
         #1;
      end
      if (sb.size() != 0) begin
         total_cnt++;
         $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
         sb.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      a_i   = '0;
      b_i   = '0;
      repeat (3) @(negedge clk);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_eq",   eq,   0);
      check("reset_gt",   gt,   0);
      check("reset_lt",   lt,   0);
      rst_n = 1'b1;
      @(negedge clk);

      // Equal operands: full scan in both configurations.
      issue(8'hA5, 8'hA5, 3'b100, 9, 1'b1);
      drain();

      // MSB differs.
      issue(8'h80, 8'h7F, 3'b010, lat(7), 1'b1);
      drain();

      // LSB differs, busy window check: cycles 1..9 high, cycle 10 low.
      issue(8'h12, 8'h13, 3'b001, 9, 1'b1);
      for (int k = 1; k <= 10; k++) begin
         if (k > 1) @(negedge clk);
         check($sformatf("busy_c%0d", k), busy, (k <= 9) ? 1 : 0);
      end
      drain();

      // Operand changes and start pulses while busy are ignored.
      issue(8'h5A, 8'h5B, 3'b001, 9, 1'b1);
      @(negedge clk);
      @(negedge clk);
      a_i = 8'hFF; b_i = 8'h00; start = 1'b1;
      @(negedge clk);
      a_i = 8'h00; b_i = 8'hFF;
      @(negedge clk);
      a_i = 8'h33;
      @(negedge clk);
      start = 1'b0;
      drain();
      repeat (12) @(negedge clk);

      // Reset in cycle 4 of a scan: everything clears, no done follows.
      issue(8'h12, 8'h13, 3'b001, 9, 1'b0);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_eq",   eq,   0);
      check("midrst_gt",   gt,   0);
      check("midrst_lt",   lt,   0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      issue(8'h01, 8'h00, 3'b010, 9, 1'b1);
      drain();

      // Back-to-back: second start in the cycle after done.
      issue(8'h80, 8'h7F, 3'b010, lat(7), 1'b1);
      begin
         bit seen;
         seen = 1'b0;
         for (int i = 0; i < 20; i++) begin
            if (done) begin
               seen = 1'b1;
               break;
            end
            @(negedge clk);
         end
         if (!seen) begin
            total_cnt++;
            $display("FAIL b2b_done_timeout: got no done expected done within 20 cycles");
         end
      end
      @(negedge clk);
      check("b2b_first_held", {eq, gt, lt}, 3'b010);
      issue(8'h00, 8'hFF, 3'b001, lat(7), 1'b1);
      check("b2b_cleared", {eq, gt, lt}, 3'b000);
      check("b2b_busy", busy, 1);
      drain();
      repeat (4) @(negedge clk);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
